// File: rtl/alu_response_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_response_checker
// Brief    : Recomputes the expected 4-op ALU result for each accepted vector,
//            scores it against the received response via a 2-stage pipeline
//            and reports pass/fail counts plus the first mismatch of a run.
// Revision : 1.0 - initial release
// ============================================================================
module alu_response_checker #(
  parameter int WIDTH        = 4,
  parameter int NUM_VECTORS  = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       pass_count,
  output logic [7:0]       fail_count,
  output logic [7:0]       first_fail_idx,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic [WIDTH-1:0] first_fail_act
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;
  localparam logic [7:0] c_LAST  = 8'(NUM_VECTORS - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       acc_q;
  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q, s1_y_q;
  logic [1:0]       s1_op_q;
  logic [7:0]       s1_idx_q, s2_idx_q;
  logic [WIDTH-1:0] s2_exp_q, s2_act_q;
  logic [7:0]       pass_cnt_q, fail_cnt_q, ff_idx_q;
  logic [WIDTH-1:0] ff_exp_q, ff_act_q;

  logic [WIDTH-1:0] w_exp;
  logic             w_accept;
  logic             w_mismatch;
  logic             w_start_run;

  assign w_accept    = in_valid && in_ready;
  assign w_mismatch  = s2_valid_q && (s2_exp_q != s2_act_q);
  assign w_start_run = start && ((state_q == c_IDLE) || (state_q == c_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE, c_DONE: begin
        if (start) state_d = c_RUN;
      end
      c_RUN: begin
        if ((w_accept && (acc_q == c_LAST)) || (STOP_ON_FAIL && w_mismatch)) begin
          state_d = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) state_d = c_DONE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == c_RUN) && (acc_q <= c_LAST);
    busy     = (state_q == c_RUN) || (state_q == c_DRAIN);
    done     = (state_q == c_DONE);
    pass     = (state_q == c_DONE) && (fail_cnt_q == 8'd0);
  end

  // Expected result from the stage-1 operands; carries are discarded.
  always_comb begin
    w_exp = '0;
    case (s1_op_q)
      2'b00:   w_exp = s1_a_q + s1_b_q + s1_c_q;
      2'b01:   w_exp = s1_a_q - s1_b_q;
      2'b10:   w_exp = s1_a_q & s1_b_q;
      default: w_exp = s1_a_q | s1_b_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      s1_a_q   <= a;
      s1_b_q   <= b;
      s1_c_q   <= c;
      s1_y_q   <= y;
      s1_op_q  <= {s1, s0};
      s1_idx_q <= acc_q;
    end
    if (s1_valid_q) begin
      s2_exp_q <= w_exp;
      s2_act_q <= s1_y_q;
      s2_idx_q <= s1_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= 8'd0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      pass_cnt_q <= 8'd0;
      fail_cnt_q <= 8'd0;
      ff_idx_q   <= 8'd0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
    end else begin
      s1_valid_q <= w_accept;
      s2_valid_q <= s1_valid_q;
      if (w_start_run) begin
        acc_q      <= 8'd0;
        pass_cnt_q <= 8'd0;
        fail_cnt_q <= 8'd0;
        ff_idx_q   <= 8'd0;
        ff_exp_q   <= '0;
        ff_act_q   <= '0;
      end else begin
        if (w_accept) acc_q <= acc_q + 8'd1;
        if (s2_valid_q) begin
          if (!w_mismatch) begin
            if (pass_cnt_q != 8'hFF) pass_cnt_q <= pass_cnt_q + 8'd1;
          end else begin
            // Only the first mismatch of a run is recorded.
            if (fail_cnt_q == 8'd0) begin
              ff_idx_q <= s2_idx_q;
              ff_exp_q <= s2_exp_q;
              ff_act_q <= s2_act_q;
            end
            if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  assign pass_count     = pass_cnt_q;
  assign fail_count     = fail_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_exp = ff_exp_q;
  assign first_fail_act = ff_act_q;

endmodule
`default_nettype wire

// File: doc/alu_response_checker.md
Name: alu_response_checker

Overview:
- Responder/monitor side of the 4-bit ALU stimulus interface. A stimulus source presents vectors {A, B, C, S1, S0} together with the ALU's response Y.
- The block recomputes the expected Y, compares it against the received Y through a 2-stage pipeline, and counts passes and failures.
- It latches details of the first mismatch and signals completion after a programmed number of vectors.
- It sits beside the ALU in the self-checking hardware test harness.

Parameters:
- WIDTH, 4, operand and result width.
- NUM_VECTORS, 8, number of accepted vectors per run; legal range 1..255.
- STOP_ON_FAIL, 0, if 1 the run ends on the first mismatch.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  vector and response present this cycle.
- in_ready  out  1  checker can accept a vector.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c  in  WIDTH  operand C.
- s0  in  1  op select bit 0.
- s1  in  1  op select bit 1.
- y  in  WIDTH  ALU response for this vector.
- busy  out  1  run in progress.
- done  out  1  run complete; held until start or rst.
- pass  out  1  valid with done; 1 iff fail_count==0.
- pass_count  out  8  matching vectors.
- fail_count  out  8  mismatching vectors.
- first_fail_idx  out  8  vector index (0-based) of first mismatch.
- first_fail_exp  out  WIDTH  expected Y of first mismatch.
- first_fail_act  out  WIDTH  received Y of first mismatch.

Behaviour:
- Reset: state IDLE. in_ready=0, busy=0, done=0, pass=0. All counts and first_fail_* are 0. Pipeline valids are cleared. rst overrides every other input, including mid-run.
- Expected result (mod 2^WIDTH, carries discarded):
  - {s1,s0}=00: A+B+C.
  - {s1,s0}=01: A-B.
  - {s1,s0}=10: A AND B.
  - {s1,s0}=11: A OR B.
- FSM states:
  - IDLE: on start, go to RUN; clear all counts and first_fail_*; clear the accept index.
  - RUN: busy=1 and in_ready=1 while accepted < NUM_VECTORS and no stop is pending. Accept happens when in_valid && in_ready.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty, then go to DONE.
  - DONE: done=1, busy=0, pass=(fail_count==0). On start, re-enter RUN with cleared counters in the same cycle.
- Pipeline:
  - Stage 1 registers a, b, c, ops, y and the index on accept.
  - Stage 2 registers the expected and received values.
  - The compare result updates the counters on the cycle after stage 2. Latency from accept to counter update is 2 cycles.
- Leaving RUN:
  - RUN goes to DRAIN in the same cycle that the NUM_VECTORS-th vector is accepted.
  - With STOP_ON_FAIL=1, a mismatch produced by the compare forces in_ready=0 from the next cycle and moves RUN to DRAIN. Vectors already in the pipeline are still scored.
- first_fail_* latch only when fail_count goes 0→1; they never update again during the run.
- Counters saturate at 255 (not reachable with a legal NUM_VECTORS; guard only).
- start while in RUN or DRAIN is ignored.
- in_valid while in_ready=0 is ignored; it is neither counted nor stalled.
- Inputs may change every cycle; there is no back-to-back penalty.
- The done→start restart and a simultaneous in_valid in that same cycle: the vector is not accepted, because in_ready is 0 in DONE.

Test Plan:
- Reset, start, then 8 correct vectors back-to-back: (15,0,1,00→0), (2,0,1,00→3), (3,3,1,01→0), (5,2,1,01→3), (10,7,1,10→2), (9,5,1,10→1), (7,1,1,11→7), (6,1,1,11→7) → done, pass=1, pass_count=8, fail_count=0.
- Same run with vector 4 given y=3 instead of 2 → fail_count=1, pass_count=7, first_fail_idx=4, first_fail_exp=2, first_fail_act=3, pass=0.
- STOP_ON_FAIL=1, mismatch at vector 1 followed by continuous in_valid → fail_count=1; vectors scored = index 0 plus those already in the pipeline (≤3); done asserted; later vectors not accepted.
- in_valid toggled with gaps, plus an in_valid pulse after the 8th accept → only 8 vectors counted; in_ready=0 after the 8th.
- rst asserted mid-run after 3 vectors → next cycle all outputs are at reset values; a fresh start gives correct full counts.
- start pulsed during RUN → ignored. start in DONE → counters clear and a second run completes correctly.
